piso_word_tx: RTL and testbench



---
 rtl/piso_word_tx_pkg.sv | 13 +
 rtl/piso_word_tx_counter.sv | 40 ++++
 rtl/piso_word_tx.sv | 141 ++++++++++++++
 tb/tb_piso_word_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/piso_word_tx_pkg.sv
// Shared definitions for the parallel-in/serial-out word transmitter:
// FSM state encoding and the bit-counter width helper.
package piso_word_tx_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Counter width for a modulo-n count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_word_tx_counter.sv
// Modulo-N bit counter with synchronous clear, count enable and a terminal-count
// flag at N-1. It saturates at N-1 rather than wrapping.
module mod_n_bit_counter
  import piso_word_tx_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] TC_VAL = W'(N - 1);

  logic [W-1:0] cnt_r;
  logic         tc_s;

  assign tc_s = (cnt_r == TC_VAL);

  // Count register: reset and clear win over enable; hold at terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
    end else if (clear) begin
      cnt_r <= {W{1'b0}};
    end else if (enable && !tc_s) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = tc_s;

endmodule

// File: rtl/piso_word_tx.sv
// Parallel-in/serial-out word transmitter: takes an N-bit word over a valid/ready
// handshake and streams it one bit per accepted beat, with zero-bubble back-to-back.
module piso_word_tx
  import piso_word_tx_pkg::*;
#(
  parameter int N         = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         sout_last,
  output logic         busy,
  output logic         done
);

  localparam int             CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  logic             state_r;
  logic             state_next_s;
  logic [N-1:0]     sreg_r;
  logic [CNT_W-1:0] cnt_s;
  logic             tc_s;
  logic             done_r;
  logic             in_shift_s;
  logic             accept_s;
  logic             last_accept_s;
  logic             load_s;

  assign in_shift_s    = (state_r == ST_SHIFT);
  assign accept_s      = in_shift_s && sout_ready;
  assign last_accept_s = accept_s && tc_s;
  // A new word loads from IDLE, or in the same cycle the previous last bit leaves.
  assign load_s        = din_valid && ((state_r == ST_IDLE) || last_accept_s);

  mod_n_bit_counter #(
    .N (N),
    .W (CNT_W)
  ) u_bit_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (load_s),
    .enable (accept_s),
    .cnt    (cnt_s),
    .tc     (tc_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (din_valid) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_accept_s && !din_valid) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Shift register: load a new word or advance one position per accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_r <= {N{1'b0}};
    end else if (load_s) begin
      sreg_r <= din;
    end else if (accept_s) begin
      if (MSB_FIRST != 0) begin
        sreg_r <= {sreg_r[N-2:0], 1'b0};
      end else begin
        sreg_r <= {1'b0, sreg_r[N-1:1]};
      end
    end else begin
      sreg_r <= sreg_r;
    end
  end

  // Completion pulse, dropped when reset aborts a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= last_accept_s;
    end
  end

  // FSM outputs; sout is gated to 0 outside SHIFT so stale bits never show.
  always_comb begin
    din_ready  = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    sout       = 1'b0;
    sout_last  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        din_ready = 1'b1;
      end
      ST_SHIFT: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout_last  = (cnt_s == LAST_IDX);
        din_ready  = sout_last && sout_ready;
        if (MSB_FIRST != 0) begin
          sout = sreg_r[N-1];
        end else begin
          sout = sreg_r[0];
        end
      end
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

  assign done = done_r;

endmodule

// File: tb/tb_piso_word_tx.sv
// Directed self-checking bench for piso_word_tx: an MSB-first and an LSB-first
// instance share all inputs; each scenario task checks the relevant instance.
module tb_piso_word_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       din_valid;
  logic       sout_ready;

  logic din_ready_m, sout_m, sout_valid_m, sout_last_m, busy_m, done_m;
  logic din_ready_l, sout_l, sout_valid_l, sout_last_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_word_tx #(.N(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_m), .sout(sout_m), .sout_valid(sout_valid_m),
    .sout_ready(sout_ready), .sout_last(sout_last_m), .busy(busy_m), .done(done_m)
  );

  piso_word_tx #(.N(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .sout(sout_l), .sout_valid(sout_valid_l),
    .sout_ready(sout_ready), .sout_last(sout_last_l), .busy(busy_l), .done(done_l)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 4'b0000; din_valid = 1'b0; sout_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    n_checks++; if (din_ready_m !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready got=%b exp=1", din_ready_m); end
    n_checks++; if (sout_valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_sout_valid got=%b exp=0", sout_valid_m); end
    n_checks++; if (sout_m !== 1'b0) begin n_fail++; $display("FAIL reset_sout got=%b exp=0", sout_m); end
    n_checks++; if (sout_last_m !== 1'b0) begin n_fail++; $display("FAIL reset_sout_last got=%b exp=0", sout_last_m); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
    n_checks++; if (done_m !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_m); end
    n_checks++; if (din_ready_l !== 1'b1 || busy_l !== 1'b0) begin n_fail++; $display("FAIL reset_lsb got rdy=%b busy=%b exp rdy=1 busy=0", din_ready_l, busy_l); end
    cyc();
  endtask

  // MSB-first and LSB-first run together on 4'b1011.
  task automatic test_basic();
    logic [3:0] exp_m;
    logic [3:0] exp_l;
    exp_m = 4'b1011;  // bits in transmit order, first at [3]
    exp_l = 4'b1101;
    din = 4'b1011; din_valid = 1'b1; sout_ready = 1'b1;
    #1;
    n_checks++; if (din_ready_m !== 1'b1) begin n_fail++; $display("FAIL basic_load_ready got=%b exp=1", din_ready_m); end
    cyc();
    din_valid = 1'b0; din = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (sout_valid_m !== 1'b1 || sout_m !== exp_m[3-i]) begin n_fail++; $display("FAIL basic_msb_beat%0d got v=%b s=%b exp v=1 s=%b", i, sout_valid_m, sout_m, exp_m[3-i]); end
      n_checks++; if (sout_last_m !== (i == 3)) begin n_fail++; $display("FAIL basic_msb_last%0d got=%b", i, sout_last_m); end
      n_checks++; if (sout_valid_l !== 1'b1 || sout_l !== exp_l[3-i]) begin n_fail++; $display("FAIL basic_lsb_beat%0d got v=%b s=%b exp v=1 s=%b", i, sout_valid_l, sout_l, exp_l[3-i]); end
      n_checks++; if (done_m !== 1'b0 || busy_m !== 1'b1) begin n_fail++; $display("FAIL basic_busy%0d got done=%b busy=%b exp done=0 busy=1", i, done_m, busy_m); end
      cyc();
    end
    n_checks++; if (done_m !== 1'b1 || done_l !== 1'b1) begin n_fail++; $display("FAIL basic_done got m=%b l=%b exp 1", done_m, done_l); end
    n_checks++; if (din_ready_m !== 1'b1 || busy_m !== 1'b0 || sout_valid_m !== 1'b0) begin n_fail++; $display("FAIL basic_idle got rdy=%b busy=%b v=%b", din_ready_m, busy_m, sout_valid_m); end
    cyc();
    n_checks++; if (done_m !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done_m); end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_m;
    exp_m = 4'b1001;
    din = 4'b1001; din_valid = 1'b1; sout_ready = 1'b1;
    cyc();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        sout_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          n_checks++; if (sout_valid_m !== 1'b1 || sout_m !== 1'b0 || sout_last_m !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d got v=%b s=%b l=%b exp v=1 s=0 l=0", s, sout_valid_m, sout_m, sout_last_m); end
          n_checks++; if (din_ready_m !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready%0d got=%b exp=0", s, din_ready_m); end
          cyc();
        end
        sout_ready = 1'b1;
      end
      #1;
      n_checks++; if (sout_valid_m !== 1'b1 || sout_m !== exp_m[3-i]) begin n_fail++; $display("FAIL bp_beat%0d got v=%b s=%b exp v=1 s=%b", i, sout_valid_m, sout_m, exp_m[3-i]); end
      n_checks++; if (sout_last_m !== (i == 3)) begin n_fail++; $display("FAIL bp_last%0d got=%b", i, sout_last_m); end
      cyc();
    end
    n_checks++; if (done_m !== 1'b1) begin n_fail++; $display("FAIL bp_done got=%b exp=1", done_m); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_m;
    int dones;
    exp_m = 8'b11000110;
    dones = 0;
    din = 4'b1100; din_valid = 1'b1; sout_ready = 1'b1;
    cyc();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        din = 4'b0110; din_valid = 1'b1;
      end
      #1;
      if (done_m === 1'b1) dones++;
      n_checks++; if (sout_valid_m !== 1'b1 || sout_m !== exp_m[7-i]) begin n_fail++; $display("FAIL b2b_beat%0d got v=%b s=%b exp v=1 s=%b", i, sout_valid_m, sout_m, exp_m[7-i]); end
      if (i == 3) begin
        n_checks++; if (din_ready_m !== 1'b1 || sout_last_m !== 1'b1) begin n_fail++; $display("FAIL b2b_handover got rdy=%b last=%b exp 1 1", din_ready_m, sout_last_m); end
      end
      cyc();
      if (i == 3) begin
        din_valid = 1'b0; din = 4'b0000;
      end
    end
    if (done_m === 1'b1) dones++;
    n_checks++; if (dones != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    cyc();
  endtask

  task automatic test_busy_ignore();
    logic [3:0] exp_m;
    exp_m = 4'b0001;
    din = 4'b0001; din_valid = 1'b1; sout_ready = 1'b1;
    cyc();
    din = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (sout_m !== exp_m[3-i]) begin n_fail++; $display("FAIL ign_beat%0d got=%b exp=%b", i, sout_m, exp_m[3-i]); end
      n_checks++; if (din_ready_m !== (i == 3)) begin n_fail++; $display("FAIL ign_ready%0d got=%b", i, din_ready_m); end
      cyc();
    end
    din_valid = 1'b0; din = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (sout_valid_m !== 1'b1 || sout_m !== 1'b1) begin n_fail++; $display("FAIL ign_second%0d got v=%b s=%b exp 1 1", i, sout_valid_m, sout_m); end
      cyc();
    end
    n_checks++; if (done_m !== 1'b1 || busy_m !== 1'b0) begin n_fail++; $display("FAIL ign_done got done=%b busy=%b exp 1 0", done_m, busy_m); end
    cyc();
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] exp_m;
    din = 4'b1010; din_valid = 1'b1; sout_ready = 1'b1;
    cyc();
    din_valid = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    n_checks++; if (sout_valid_m !== 1'b0 || busy_m !== 1'b0 || din_ready_m !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state got v=%b busy=%b rdy=%b exp 0 0 1", sout_valid_m, busy_m, din_ready_m); end
    n_checks++; if (done_m !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b exp=0", done_m); end
    cyc();
    n_checks++; if (done_m !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done_late got=%b exp=0", done_m); end
    exp_m = 4'b0101;
    din = 4'b0101; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (sout_valid_m !== 1'b1 || sout_m !== exp_m[3-i]) begin n_fail++; $display("FAIL rst_next_beat%0d got v=%b s=%b exp v=1 s=%b", i, sout_valid_m, sout_m, exp_m[3-i]); end
      cyc();
    end
    n_checks++; if (done_m !== 1'b1) begin n_fail++; $display("FAIL rst_next_done got=%b exp=1", done_m); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
